// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction RAM target for the fetch stage,
// with programmable wait states, fault flagging and a backdoor program-load port.
// Optional feature macro: IMEM_LAST_HIT_EN adds a one-entry last-fetch buffer
// that answers a repeated address without wait states.
module imem_responder #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH       = 1024,
    parameter int unsigned     WAIT_STATES = 1,
    parameter logic [XLEN-1:0] BASE_ADDR   = XLEN'(32'h0000_0000)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     imem_req,
    input  logic [XLEN-1:0]          imem_addr,
    output logic [XLEN-1:0]          imem_rdata,
    output logic                     imem_ready,
    output logic                     imem_fault,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [XLEN-1:0]          prog_wdata,
    output logic                     busy
);

    localparam int unsigned      IDX_W = $clog2(DEPTH);
    localparam int unsigned      CNT_W = 4;
    localparam logic [XLEN-1:0]  NOP   = XLEN'(32'h0000_0013);
    localparam logic [CNT_W-1:0] WS    = CNT_W'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  addr_q;
    logic [IDX_W-1:0] idx_q;
    logic             fault_q;

    logic [XLEN-1:0]  mem [DEPTH];

    logic [XLEN:0]    diff_c;
    logic [IDX_W-1:0] req_idx_c;
    logic             req_fault_c;
    logic             hit_c;
    logic [XLEN-1:0]  hit_data_c;
    logic             fast_c;
    logic             accept_c;
    logic             enter_resp_c;
    logic             ent_fault_c;
    logic             ent_hit_c;
    logic [IDX_W-1:0] ent_idx_c;
    logic [XLEN-1:0]  ent_data_c;

    // Request decode: the borrow bit flags addresses below the base, any offset
    // bit above the array span flags out-of-range. BASE_ADDR is word aligned,
    // so the low offset bits equal the low address bits.
    assign diff_c      = {1'b0, imem_addr} - {1'b0, BASE_ADDR};
    assign req_idx_c   = diff_c[IDX_W+1:2];
    assign req_fault_c = ((imem_addr[1:0] | diff_c[1:0]) != 2'b00)
                       || diff_c[XLEN]
                       || (diff_c[XLEN-1:IDX_W+2] != '0);

`ifdef IMEM_LAST_HIT_EN
    logic             buf_valid;
    logic [XLEN-1:0]  buf_addr;
    logic [IDX_W-1:0] buf_idx;
    logic [XLEN-1:0]  buf_data;
    logic [XLEN-1:0]  ent_addr_c;

    assign hit_c      = buf_valid && (imem_addr == buf_addr);
    assign hit_data_c = buf_data;
    assign ent_addr_c = accept_c ? imem_addr : addr_q;
`else
    assign hit_c      = 1'b0;
    assign hit_data_c = '0;
`endif

    assign fast_c = (WS == CNT_W'(0)) || hit_c;

    // Accept / respond decisions for the coming edge and the response payload
    always_comb begin
        accept_c     = 1'b0;
        enter_resp_c = 1'b0;
        ent_fault_c  = fault_q;
        ent_hit_c    = 1'b0;
        ent_idx_c    = idx_q;
        case (state)
            IDLE:    accept_c = imem_req;
            WAIT:    accept_c = imem_req && (imem_addr != addr_q);
            RESP:    accept_c = imem_req;
            default: accept_c = 1'b0;
        endcase
        if (accept_c) begin
            enter_resp_c = fast_c;
            ent_fault_c  = req_fault_c;
            ent_hit_c    = hit_c;
            ent_idx_c    = req_idx_c;
        end else if (state == WAIT && imem_req && cnt == CNT_W'(1)) begin
            enter_resp_c = 1'b1;
        end
    end

    // Array is read on the edge entering RESP; faulted accesses return NOP
    assign ent_data_c = ent_fault_c ? NOP : (ent_hit_c ? hit_data_c : mem[ent_idx_c]);

    // Backdoor program load; array contents have no reset
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // Access FSM: accept, count wait states, one-cycle response, abort on change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            fault_q    <= 1'b0;
            imem_ready <= 1'b0;
            imem_fault <= 1'b0;
            imem_rdata <= NOP;
            busy       <= 1'b0;
        end else begin
            imem_ready <= 1'b0;
            imem_fault <= 1'b0;
            imem_rdata <= NOP;
            if (enter_resp_c) begin
                imem_ready <= 1'b1;
                imem_fault <= ent_fault_c;
                imem_rdata <= ent_data_c;
            end
            if (accept_c) begin
                addr_q  <= imem_addr;
                idx_q   <= req_idx_c;
                fault_q <= req_fault_c;
                cnt     <= fast_c ? CNT_W'(0) : WS;
                state   <= fast_c ? RESP : WAIT;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    WAIT: begin
                        if (!imem_req) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else if (cnt == CNT_W'(1)) begin
                            state <= RESP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    RESP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef IMEM_LAST_HIT_EN
    // Last-fetch buffer: loaded on each non-faulted response, dropped when the
    // backdoor overwrites the buffered word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_idx   <= '0;
            buf_data  <= '0;
        end else if (enter_resp_c && !ent_fault_c) begin
            buf_valid <= !(prog_we && (prog_addr == ent_idx_c));
            buf_addr  <= ent_addr_c;
            buf_idx   <= ent_idx_c;
            buf_data  <= ent_data_c;
        end else if (prog_we && (prog_addr == buf_idx)) begin
            buf_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: four instances share stimulus, with
// WAIT_STATES 0, 2, 3 and 4; each scenario checks the instance it targets.
module tb_imem_responder;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned NI    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_LAST_HIT_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 5;
`endif

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [31:0] prog_wdata;

    logic [31:0] rdata [NI];
    logic        ready [NI];
    logic        fault [NI];
    logic        busy  [NI];

    int errors = 0;
    int checks = 0;

    logic [31:0] t2_exp [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        imem_responder #(
            .XLEN        (XLEN),
            .DEPTH       (DEPTH),
            .WAIT_STATES ((g == 0) ? 0 : g + 1),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .imem_req   (imem_req),
            .imem_addr  (imem_addr),
            .imem_rdata (rdata[g]),
            .imem_ready (ready[g]),
            .imem_fault (fault[g]),
            .prog_we    (prog_we),
            .prog_addr  (prog_addr),
            .prog_wdata (prog_wdata),
            .busy       (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic prog(input logic [9:0] idx, input logic [31:0] d);
        prog_we    = 1'b1;
        prog_addr  = idx;
        prog_wdata = d;
        @(posedge clk); #1;
        prog_we    = 1'b0;
    endtask

    // Hold a request on instance i until it answers; lat counts edges from acceptance
    task automatic fetch(input int i, input logic [31:0] a, input string tag,
                         output int lat, output logic [31:0] rd, output logic flt);
        logic got = 1'b0;
        imem_req  = 1'b1;
        imem_addr = a;
        lat = 0;
        rd  = '0;
        flt = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (k == 0) check({tag, " busy"}, 32'(busy[i]), 32'd1);
            if (ready[i]) begin
                got = 1'b1;
                rd  = rdata[i];
                flt = fault[i];
            end
        end
        check({tag, " responded"}, 32'(got), 32'd1);
        imem_req = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready drop"}, 32'(ready[i]), 32'd0);
        check({tag, " rdata nop"}, rdata[i], NOP);
        check({tag, " idle"}, 32'(busy[i]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          nready;
        logic        got;
        logic [31:0] rd;
        logic        flt;

        rst_n      = 1'b0;
        imem_req   = 1'b0;
        imem_addr  = '0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        t2_exp     = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < int'(NI); i++) begin
            check($sformatf("rst%0d ready", i), 32'(ready[i]), 32'd0);
            check($sformatf("rst%0d fault", i), 32'(fault[i]), 32'd0);
            check($sformatf("rst%0d rdata", i), rdata[i], NOP);
            check($sformatf("rst%0d busy", i), 32'(busy[i]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle no req busy", 32'(busy[1]), 32'd0);
        check("idle no req rdata", rdata[1], NOP);

        prog(10'd4,    32'h00A0_0093);
        prog(10'd0,    t2_exp[0]);
        prog(10'd1,    t2_exp[1]);
        prog(10'd2,    t2_exp[2]);
        prog(10'd8,    32'h0DEA_D013);
        prog(10'd16,   32'h0040_0213);
        prog(10'd1023, 32'hFFF0_0F13);

        // WAIT_STATES=2 basic fetch
        fetch(1, 32'h0000_0010, "t1", lat, rd, flt);
        check("t1 latency", 32'(lat), 32'd3);
        check("t1 rdata", rd, 32'h00A0_0093);
        check("t1 fault", 32'(flt), 32'd0);

        // WAIT_STATES=0 streaming, address steps every cycle
        for (int k = 0; k < 3; k++) begin
            imem_req  = 1'b1;
            imem_addr = 32'(k * 4);
            @(posedge clk); #1;
            check($sformatf("t2 ready%0d", k), 32'(ready[0]), 32'd1);
            check($sformatf("t2 rdata%0d", k), rdata[0], t2_exp[k]);
        end
        imem_req = 1'b0;
        @(posedge clk); #1;
        check("t2 ready drop", 32'(ready[0]), 32'd0);

        // Faults and last in-range word
        fetch(1, 32'h0000_0012, "t3 misaligned", lat, rd, flt);
        check("t3 misaligned lat", 32'(lat), 32'd3);
        check("t3 misaligned fault", 32'(flt), 32'd1);
        check("t3 misaligned rdata", rd, NOP);
        fetch(1, 32'h0000_1000, "t3 range", lat, rd, flt);
        check("t3 range fault", 32'(flt), 32'd1);
        check("t3 range rdata", rd, NOP);
        fetch(1, 32'h0000_0FFC, "t3 last", lat, rd, flt);
        check("t3 last fault", 32'(flt), 32'd0);
        check("t3 last rdata", rd, 32'hFFF0_0F13);

        // WAIT_STATES=3 abort by address change on the second WAIT cycle
        imem_req  = 1'b1;
        imem_addr = 32'h0000_0020;
        @(posedge clk); #1;
        check("t4 busy", 32'(busy[2]), 32'd1);
        check("t4 ready w1", 32'(ready[2]), 32'd0);
        @(posedge clk); #1;
        check("t4 ready w2", 32'(ready[2]), 32'd0);
        imem_addr = 32'h0000_0040;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (ready[2]) begin
                got = 1'b1;
                rd  = rdata[2];
            end
        end
        check("t4 responded", 32'(got), 32'd1);
        check("t4 latency", 32'(lat), 32'd4);
        check("t4 rdata", rd, 32'h0040_0213);
        imem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset pulse during WAIT on WAIT_STATES=4
        imem_req  = 1'b1;
        imem_addr = 32'h0000_0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5 busy", 32'(busy[3]), 32'd1);
        rst_n    = 1'b0;
        imem_req = 1'b0;
        #2;
        check("t5 async busy", 32'(busy[3]), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        nready = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready[3]) nready++;
        end
        check("t5 no ready", 32'(nready), 32'd0);
        check("t5 rdata", rdata[3], NOP);
        check("t5 fault", 32'(fault[3]), 32'd0);
        check("t5 busy idle", 32'(busy[3]), 32'd0);

        // Repeated fetch on WAIT_STATES=4, then backdoor overwrite of that word
        prog(10'd2, t2_exp[2]);
        fetch(3, 32'h0000_0008, "t6 first", lat, rd, flt);
        check("t6 first lat", 32'(lat), 32'd5);
        check("t6 first rdata", rd, t2_exp[2]);
        fetch(3, 32'h0000_0008, "t6 repeat", lat, rd, flt);
        check("t6 repeat lat", 32'(lat), 32'(HIT_LAT));
        check("t6 repeat rdata", rd, t2_exp[2]);
        prog(10'd2, 32'h00B0_0113);
        fetch(3, 32'h0000_0008, "t6 rewritten", lat, rd, flt);
        check("t6 rewritten lat", 32'(lat), 32'd5);
        check("t6 rewritten rdata", rd, 32'h00B0_0113);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
